// File: rtl/cache_controller_pkg.sv
// Shared constants and state encoding for the direct-mapped cache controller.
// Address layout (word address): tag [14:12], index [11:2], offset [1:0].
package cache_controller_pkg;

  localparam int unsigned WORD_LENGTH     = 32;
  localparam int unsigned ADDR_WIDTH      = 15;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned OFS_WIDTH       = 2;
  localparam int unsigned BLOCK_WIDTH     = ADDR_WIDTH - OFS_WIDTH;
  localparam int unsigned LINE_WIDTH      = WORD_LENGTH * WORDS_PER_BLOCK;
  localparam int unsigned SETS            = 1024;
  localparam int unsigned TAG_START       = 14;
  localparam int unsigned TAG_END         = 12;
  localparam int unsigned IDX_START       = 11;
  localparam int unsigned IDX_END         = 2;
  // Valid bit sits above the line data and tag in a cache entry.
  localparam int unsigned VALID           = LINE_WIDTH + (TAG_START - TAG_END + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FETCH,
    FILL,
    RESP
  } ctrl_state_e;

  // Block number (tag + index) of a word address.
  function automatic logic [BLOCK_WIDTH-1:0] block_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:OFS_WIDTH];
  endfunction

endpackage

// File: rtl/cache_fill_buffer.sv
// Four-word line buffer filled one word at a time from main memory.
// Ports: clk, rst (sync, active-high), we_i/wr_idx_i/wr_data_i write port,
// rd_ofs_i selects word_o, line_o is the whole line (offset 00 in the MSBs).
module cache_fill_buffer
  import cache_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [OFS_WIDTH-1:0]   wr_idx_i,
  input  logic [WORD_LENGTH-1:0] wr_data_i,
  input  logic [OFS_WIDTH-1:0]   rd_ofs_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic [WORD_LENGTH-1:0] word_o
);

  logic [WORD_LENGTH-1:0] mem_q [WORDS_PER_BLOCK];

  // Word register file; reset discards any partially fetched line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign line_o = {mem_q[0], mem_q[1], mem_q[2], mem_q[3]};
  assign word_o = mem_q[rd_ofs_i];

endmodule

// File: rtl/cache_controller.sv
// Read-miss sequencer in front of a direct-mapped cache: lookup, 4-word
// memory fetch, single-cycle line commit, and word return to the CPU.
// Ports: clk/rst; CPU side cpu_read, cpu_address, cpu_ready, cpu_data;
// cache side cache_address, cache_hit, cache_out, cache_write, cache_data1..4;
// memory side mem_read, mem_address, mem_data, mem_ready.
// Optional macro CACHE_CTRL_STATS_EN adds saturating hit_count/miss_count.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_read,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  output logic                   cpu_ready,
  output logic [WORD_LENGTH-1:0] cpu_data,
  output logic [ADDR_WIDTH-1:0]  cache_address,
  input  logic                   cache_hit,
  input  logic [WORD_LENGTH-1:0] cache_out,
  output logic                   cache_write,
  output logic [WORD_LENGTH-1:0] cache_data1,
  output logic [WORD_LENGTH-1:0] cache_data2,
  output logic [WORD_LENGTH-1:0] cache_data3,
  output logic [WORD_LENGTH-1:0] cache_data4,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [WORD_LENGTH-1:0] mem_data,
  input  logic                   mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  ctrl_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic [WORD_LENGTH-1:0] cpu_data_q, cpu_data_d;
  logic                   cache_write_q, cache_write_d;
  logic                   mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]  mem_address_q, mem_address_d;
  logic [OFS_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [BLOCK_WIDTH-1:0] fb_block_q, fb_block_d;
  logic                   fb_valid_q, fb_valid_d;

  logic                   fb_we_c;
  logic                   fb_hit_c;
  logic [OFS_WIDTH-1:0]   word_cnt_inc_c;
  logic [LINE_WIDTH-1:0]  line_c;
  logic [WORD_LENGTH-1:0] fb_word_c;

  assign fb_we_c        = (state_q == FETCH) && mem_ready;
  assign fb_hit_c       = fb_valid_q && (block_of(req_addr_q) == fb_block_q);
  assign word_cnt_inc_c = word_cnt_q + OFS_WIDTH'(1);

  cache_fill_buffer u_fill_buf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (fb_we_c),
    .wr_idx_i  (word_cnt_q),
    .wr_data_i (mem_data),
    .rd_ofs_i  (req_addr_q[OFS_WIDTH-1:0]),
    .line_o    (line_c),
    .word_o    (fb_word_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_data_q    <= '0;
      cache_write_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      word_cnt_q    <= '0;
      fb_block_q    <= '0;
      fb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_data_q    <= cpu_data_d;
      cache_write_q <= cache_write_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      word_cnt_q    <= word_cnt_d;
      fb_block_q    <= fb_block_d;
      fb_valid_q    <= fb_valid_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    cpu_ready_d   = 1'b0;
    cpu_data_d    = cpu_data_q;
    cache_write_d = 1'b0;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    word_cnt_d    = word_cnt_q;
    fb_block_d    = fb_block_q;
    fb_valid_d    = fb_valid_q;

    case (state_q)
      IDLE: begin
        // The CPU still holds cpu_read during the ready cycle; skip it.
        if (cpu_read && !cpu_ready_q) begin
          req_addr_d = cpu_address;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        // Line buffer wins: the cache does not re-evaluate an unchanged address.
        if (fb_hit_c) begin
          cpu_data_d = fb_word_c;
          state_d    = RESP;
        end else if (cache_hit) begin
          cpu_data_d = cache_out;
          state_d    = RESP;
        end else begin
          word_cnt_d    = '0;
          mem_read_d    = 1'b1;
          mem_address_d = {block_of(req_addr_q), OFS_WIDTH'(0)};
          fb_valid_d    = 1'b0;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          word_cnt_d = word_cnt_inc_c;
          if (word_cnt_q == OFS_WIDTH'(WORDS_PER_BLOCK - 1)) begin
            mem_read_d    = 1'b0;
            cache_write_d = 1'b1;
            state_d       = FILL;
          end else begin
            mem_address_d = {block_of(req_addr_q), word_cnt_inc_c};
          end
        end
      end
      FILL: begin
        fb_block_d = block_of(req_addr_q);
        fb_valid_d = 1'b1;
        cpu_data_d = fb_word_c;
        state_d    = RESP;
      end
      RESP: begin
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_ready     = cpu_ready_q;
  assign cpu_data      = cpu_data_q;
  assign cache_address = req_addr_q;
  assign cache_write   = cache_write_q;
  assign mem_read      = mem_read_q;
  assign mem_address   = mem_address_q;
  assign cache_data1   = line_c[127:96];
  assign cache_data2   = line_c[95:64];
  assign cache_data3   = line_c[63:32];
  assign cache_data4   = line_c[31:0];

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        lookup_c;

  assign lookup_c = (state_q == LOOKUP);

  // Saturating lookup outcome counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (lookup_c) begin
      if ((fb_hit_c || cache_hit) && (hit_count_q != 16'hFFFF))
        hit_count_q <= hit_count_q + 16'd1;
      if (!fb_hit_c && !cache_hit && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        cpu_read;
  logic [14:0] cpu_address;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic [14:0] cache_address;
  logic        cache_hit;
  logic [31:0] cache_out;
  logic        cache_write;
  logic [31:0] cache_data1, cache_data2, cache_data3, cache_data4;
  logic        mem_read;
  logic [14:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ready;

  int n_checks;
  int n_fail;

  // Memory model configuration and observation
  int          mem_gap;
  logic [31:0] mem_base;
  int          fetch_cyc;
  int          words_seen;
  int          writes_seen;
  bit          mem_read_seen;

  logic [14:0]  exp_mem_addr_q[$];
  logic [127:0] exp_line_q[$];
  logic [31:0]  exp_resp_q[$];

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_read      (cpu_read),
    .cpu_address   (cpu_address),
    .cpu_ready     (cpu_ready),
    .cpu_data      (cpu_data),
    .cache_address (cache_address),
    .cache_hit     (cache_hit),
    .cache_out     (cache_out),
    .cache_write   (cache_write),
    .cache_data1   (cache_data1),
    .cache_data2   (cache_data2),
    .cache_data3   (cache_data3),
    .cache_data4   (cache_data4),
    .mem_read      (mem_read),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory responder plus address/line-commit monitors
  always @(negedge clk) begin
    logic [14:0]  ea;
    logic [127:0] el;
    logic [127:0] got_line;
    mem_ready = 1'b0;
    if (mem_read) begin
      mem_read_seen = 1'b1;
      fetch_cyc++;
      if (fetch_cyc % mem_gap == 0) begin
        mem_ready = 1'b1;
        mem_data  = mem_base + 32'(mem_address[1:0]);
        words_seen++;
        n_checks++;
        if (exp_mem_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_address unexpected fetch: got %h, none expected", mem_address);
        end else begin
          ea = exp_mem_addr_q.pop_front();
          if (mem_address !== ea) begin
            n_fail++;
            $display("FAIL mem_address: got %h, required %h", mem_address, ea);
          end
        end
      end
    end else begin
      fetch_cyc = 0;
    end
    if (cache_write) begin
      writes_seen++;
      got_line = {cache_data1, cache_data2, cache_data3, cache_data4};
      n_checks++;
      if (exp_line_q.size() == 0) begin
        n_fail++;
        $display("FAIL cache_write unexpected: line %h", got_line);
      end else begin
        el = exp_line_q.pop_front();
        if (got_line !== el) begin
          n_fail++;
          $display("FAIL cache_line: got %h, required %h", got_line, el);
        end
      end
    end
  end

  // One CPU read; miss=1 means a full 4-word fetch and one line commit are expected.
  task automatic issue_read(input logic [14:0] addr, input logic hit, input logic [31:0] hout,
                            input logic [31:0] exp_data, input int exp_lat, input int gap,
                            input logic [31:0] base, input bit miss, input string name);
    int          cycles;
    bit          got;
    logic [31:0] exp_d;
    @(negedge clk);
    mem_gap       = gap;
    mem_base      = base;
    words_seen    = 0;
    writes_seen   = 0;
    mem_read_seen = 1'b0;
    exp_resp_q.push_back(exp_data);
    if (miss) begin
      for (int k = 0; k < 4; k++) exp_mem_addr_q.push_back({addr[14:2], 2'(k)});
      exp_line_q.push_back({base, base + 32'd1, base + 32'd2, base + 32'd3});
    end
    cpu_address = addr;
    cpu_read    = 1'b1;
    cache_hit   = hit;
    cache_out   = hout;
    @(posedge clk);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 300) begin
      @(posedge clk);
      cycles++;
      #1;
      if (cpu_ready === 1'b1) got = 1'b1;
    end
    exp_d = exp_resp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no cpu_ready within %0d cycles, required latency %0d", name, cycles, exp_lat);
    end else begin
      if (cycles != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, required %0d", name, cycles, exp_lat);
      end
      n_checks++;
      if (cpu_data !== exp_d) begin
        n_fail++;
        $display("FAIL %s cpu_data: got %h, required %h", name, cpu_data, exp_d);
      end
      n_checks++;
      if (cache_address !== addr) begin
        n_fail++;
        $display("FAIL %s cache_address: got %h, required %h", name, cache_address, addr);
      end
    end
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    n_checks++;
    if (cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_pulse: cpu_ready got %b, required 0", name, cpu_ready);
    end
    n_checks++;
    if (words_seen != (miss ? 4 : 0) || writes_seen != (miss ? 1 : 0) || mem_read_seen != miss) begin
      n_fail++;
      $display("FAIL %s traffic: words %0d writes %0d mem_read %0b, required %0d %0d %0b",
               name, words_seen, writes_seen, mem_read_seen, miss ? 4 : 0, miss ? 1 : 0, miss);
    end
    cache_hit = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (cpu_ready !== 1'b0 || cpu_data !== 32'h0 || cache_write !== 1'b0 || mem_read !== 1'b0 ||
        mem_address !== 15'h0 || cache_address !== 15'h0) begin
      n_fail++;
      $display("FAIL %s: ready %b data %h wr %b mrd %b maddr %h caddr %h, required all 0",
               name, cpu_ready, cpu_data, cache_write, mem_read, mem_address, cache_address);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    @(negedge clk);
    mem_gap     = 1;
    mem_base    = 32'hB0;
    words_seen  = 0;
    writes_seen = 0;
    for (int k = 0; k < 4; k++) exp_mem_addr_q.push_back({13'(15'h1234 >> 2), 2'(k)});
    cpu_address = 15'h1234;
    cpu_read    = 1'b1;
    cache_hit   = 1'b0;
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    cyc = 0;
    while (words_seen < 2 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (words_seen < 2) begin
      n_fail++;
      $display("FAIL midfetch_start: words %0d, required 2", words_seen);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midfetch_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (writes_seen != 0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL midfetch_quiet: writes %0d mem_read %b, required 0 0", writes_seen, mem_read);
    end
    exp_mem_addr_q.delete();
  endtask

  task automatic test_cold_miss();
    issue_read(15'h1234, 1'b0, 32'h0, 32'hA0, 7, 1, 32'hA0, 1'b1, "cold_miss");
  endtask

  task automatic test_line_buffer();
    issue_read(15'h1236, 1'b0, 32'h0, 32'hA2, 2, 1, 32'hEE, 1'b0, "line_buffer");
  endtask

  task automatic test_cache_hit();
    issue_read(15'h0010, 1'b1, 32'hDEAD, 32'hDEAD, 2, 1, 32'hEE, 1'b0, "cache_hit");
  endtask

  task automatic test_gapped();
    issue_read(15'h2A5B, 1'b0, 32'h0, 32'hC3, 15, 3, 32'hC0, 1'b1, "gapped_miss");
  endtask

  task automatic test_conflict();
    issue_read(15'h1234, 1'b0, 32'h0, 32'hA0, 7, 1, 32'hA0, 1'b1, "conflict_first");
    issue_read(15'h5235, 1'b0, 32'h0, 32'h51, 7, 1, 32'h50, 1'b1, "conflict_evict");
    issue_read(15'h1237, 1'b0, 32'h0, 32'h63, 7, 1, 32'h60, 1'b1, "conflict_refetch");
  endtask

  task automatic test_back_to_back();
    issue_read(15'h0444, 1'b1, 32'h1111, 32'h1111, 2, 1, 32'hEE, 1'b0, "b2b_hit0");
    issue_read(15'h0888, 1'b1, 32'h2222, 32'h2222, 2, 1, 32'hEE, 1'b0, "b2b_hit1");
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    cpu_read      = 1'b0;
    cpu_address   = '0;
    cache_hit     = 1'b0;
    cache_out     = '0;
    mem_data      = '0;
    mem_ready     = 1'b0;
    mem_gap       = 1;
    mem_base      = '0;
    fetch_cyc     = 0;
    words_seen    = 0;
    writes_seen   = 0;
    mem_read_seen = 1'b0;

    test_reset();
    test_reset_mid_fetch();
    test_cold_miss();
    test_line_buffer();
    test_cache_hit();
    test_gapped();
    test_conflict();
    test_back_to_back();

    n_checks++;
    if (exp_mem_addr_q.size() != 0 || exp_line_q.size() != 0 || exp_resp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left addr %0d line %0d resp %0d, required 0 0 0",
               exp_mem_addr_q.size(), exp_line_q.size(), exp_resp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
